// File: rtl/scan_ckpt_ctrl.sv
// Scan checkpoint controller: pauses the target, streams the FF scan chain and then
// the RAM scan chain out (dump) or in (load), then returns the target to run mode.
module scan_ckpt_ctrl #(
  parameter int unsigned FF_WORDS  = 16,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        host_clk,
  input  logic        host_rst_n,
  input  logic        cmd_valid,
  input  logic        cmd_dir,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic        run_mode,
  output logic        scan_mode,
  output logic        ff_se,
  output logic [63:0] ff_di,
  input  logic [63:0] ff_do,
  output logic        ram_sr,
  output logic        ram_se,
  output logic        ram_sd,
  output logic [63:0] ram_di,
  input  logic [63:0] ram_do,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [63:0] dout_data,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [63:0] din_data
);

  localparam int unsigned MaxWords = (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS;
  localparam int unsigned CntW     = $clog2(MaxWords + 1);

  localparam logic [CntW-1:0] FfLast    = CntW'(FF_WORDS - 1);
  localparam logic [CntW-1:0] MemLast   = CntW'(MEM_WORDS - 1);
  localparam logic [CntW-1:0] PrimeLast = CntW'(1);

  typedef enum logic [3:0] {
    StIdle,
    StPause,
    StScanEn,
    StFf,
    StRamPrime,
    StRam,
    StRamFlush,
    StUnscan,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic            dir_q, dir_d;     // 0 = dump, 1 = load
  logic [CntW-1:0] cnt_q, cnt_d;

  // State, direction and word counter registers.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; everything defaults to the inactive value.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    cmd_ready  = 1'b0;
    busy       = (state_q != StIdle);
    done       = 1'b0;
    run_mode   = 1'b0;
    scan_mode  = 1'b0;
    ff_se      = 1'b0;
    ff_di      = '0;
    ram_sr     = 1'b0;
    ram_se     = 1'b0;
    ram_sd     = 1'b0;
    ram_di     = '0;
    dout_valid = 1'b0;
    dout_data  = '0;
    din_ready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        run_mode  = 1'b1;
        // Held low while reset is asserted so the host cannot see a ready idle.
        cmd_ready = host_rst_n;
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          state_d = StPause;
        end
      end
      StPause: begin
        state_d = StScanEn;
      end
      StScanEn: begin
        scan_mode = 1'b1;
        ram_sr    = 1'b1;
        cnt_d     = '0;
        state_d   = StFf;
      end
      StFf: begin
        scan_mode = 1'b1;
        if (!dir_q) begin
          // Dump recirculates the chain so the target state is preserved.
          dout_valid = 1'b1;
          dout_data  = ff_do;
          ff_se      = dout_ready;
          ff_di      = ff_do;
        end else begin
          din_ready = 1'b1;
          ff_se     = din_valid;
          ff_di     = din_data;
        end
        if (ff_se) begin
          if (cnt_q == FfLast) begin
            cnt_d   = '0;
            state_d = dir_q ? StRam : StRamPrime;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRamPrime: begin
        // Two reads in flight before the first RAM word is valid on ram_do.
        scan_mode = 1'b1;
        ram_se    = 1'b1;
        if (cnt_q == PrimeLast) begin
          cnt_d   = '0;
          state_d = StRam;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRam: begin
        scan_mode = 1'b1;
        if (!dir_q) begin
          dout_valid = 1'b1;
          dout_data  = ram_do;
          ram_se     = dout_ready;
        end else begin
          ram_sd    = 1'b1;
          din_ready = 1'b1;
          ram_se    = din_valid;
          ram_di    = din_data;
        end
        if (ram_se) begin
          if (cnt_q == MemLast) begin
            cnt_d   = '0;
            state_d = dir_q ? StRamFlush : StUnscan;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRamFlush: begin
        // Commits the last buffered write word.
        scan_mode = 1'b1;
        ram_se    = 1'b1;
        ram_sd    = 1'b1;
        state_d   = StUnscan;
      end
      StUnscan: begin
        state_d = StDone;
      end
      StDone: begin
        run_mode = 1'b1;
        done     = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule
